mem_port_arbiter: RTL and testbench

//  Shares one single-port SRAM between the core's instruction-fetch and data (load/store) requesters,

---
 rtl/mem_port_arbiter.sv | 110 +++++++++++
 tb/tb_mem_port_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one single-port SRAM between the instruction-fetch and
//            load/store requesters. Optional perf counters: ARB_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_gnt,
  output logic                inst_rvalid,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic [DATA_W/8-1:0] data_we,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_gnt,
  output logic                data_rvalid,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stallreq
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [63:0]         perf_inst_gnt,
  output logic [63:0]         perf_data_gnt,
  output logic [63:0]         perf_conflict
`endif
);

  localparam logic [3:0] c_starve_max = 4'(STARVE_MAX);
  localparam logic       c_owner_inst = 1'b0;
  localparam logic       c_owner_data = 1'b1;

  logic [3:0] r_starve_cnt;
  logic       r_rd_pend;
  logic       r_rd_owner;

  logic w_inst_gnt;
  logic w_data_gnt;
  logic w_data_rd;

  // Data wins unless the fetch side has waited out its starvation budget.
  assign w_inst_gnt = rst_n & inst_req & (~data_req | (r_starve_cnt == c_starve_max));
  assign w_data_gnt = rst_n & data_req & ~w_inst_gnt;
  assign w_data_rd  = (data_we == '0);

  assign inst_gnt  = w_inst_gnt;
  assign data_gnt  = w_data_gnt;
  assign mem_en    = w_inst_gnt | w_data_gnt;
  assign mem_we    = w_data_gnt ? data_we : '0;
  assign mem_wdata = w_data_gnt ? data_wdata : '0;
  assign mem_addr  = w_inst_gnt ? inst_addr : (w_data_gnt ? data_addr : '0);
  assign stallreq  = rst_n & ((inst_req & ~w_inst_gnt) | (data_req & ~w_data_gnt));

  assign inst_rvalid = r_rd_pend & (r_rd_owner == c_owner_inst);
  assign data_rvalid = r_rd_pend & (r_rd_owner == c_owner_data);
  assign inst_rdata  = inst_rvalid ? mem_rdata : '0;
  assign data_rdata  = data_rvalid ? mem_rdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
      r_rd_pend    <= 1'b0;
      r_rd_owner   <= c_owner_inst;
    end else begin
      r_rd_pend  <= w_inst_gnt | (w_data_gnt & w_data_rd);
      r_rd_owner <= w_data_gnt ? c_owner_data : c_owner_inst;
      if (w_inst_gnt || !inst_req) begin
        r_starve_cnt <= '0;
      end else if (w_data_gnt && (r_starve_cnt != c_starve_max)) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [63:0] r_perf_inst_gnt;
  logic [63:0] r_perf_data_gnt;
  logic [63:0] r_perf_conflict;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_inst_gnt <= '0;
      r_perf_data_gnt <= '0;
      r_perf_conflict <= '0;
    end else begin
      if (w_inst_gnt)           r_perf_inst_gnt <= r_perf_inst_gnt + 64'd1;
      if (w_data_gnt)           r_perf_data_gnt <= r_perf_data_gnt + 64'd1;
      if (inst_req && data_req) r_perf_conflict <= r_perf_conflict + 64'd1;
    end
  end

  assign perf_inst_gnt = r_perf_inst_gnt;
  assign perf_data_gnt = r_perf_data_gnt;
  assign perf_conflict = r_perf_conflict;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Vector table plus scoreboard for mem_port_arbiter read returns.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inst_req;
  logic [63:0] inst_addr;
  logic        inst_gnt, inst_rvalid;
  logic [63:0] inst_rdata;
  logic        data_req;
  logic [7:0]  data_we;
  logic [63:0] data_addr, data_wdata;
  logic        data_gnt, data_rvalid;
  logic [63:0] data_rdata;
  logic        mem_en;
  logic [7:0]  mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic [63:0] mem_rdata = '0;
  logic        stallreq;
`ifdef ARB_PERF_CNT_EN
  logic [63:0] perf_inst_gnt, perf_data_gnt, perf_conflict;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_gnt(inst_gnt),
    .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_gnt(data_gnt),
    .data_rvalid(data_rvalid), .data_rdata(data_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stallreq(stallreq)
`ifdef ARB_PERF_CNT_EN
    , .perf_inst_gnt(perf_inst_gnt), .perf_data_gnt(perf_data_gnt),
    .perf_conflict(perf_conflict)
`endif
  );

  // SRAM stand-in: read data is a fixed scramble of the address, one cycle later.
  function automatic logic [63:0] mem_f(input logic [63:0] a);
    return a ^ 64'hA5A5_0000_5A5A_FFFF;
  endfunction

  always @(posedge clk) begin
    if (mem_en && mem_we == 8'h00) mem_rdata <= mem_f(mem_addr);
    else                           mem_rdata <= 64'hDEAD_BEEF_DEAD_BEEF;
  end

  typedef struct {
    logic        ir;
    logic [63:0] ia;
    logic        dr;
    logic [7:0]  dwe;
    logic [63:0] da;
    logic [63:0] dwd;
    logic        eig;
    logic        edg;
  } vec_t;

  typedef struct {
    logic        iv;
    logic        dv;
    logic [63:0] rd;
  } sb_t;

  vec_t vecs[$];
  sb_t  sbq[$];

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic add(input logic ir, input logic [63:0] ia, input logic dr,
                     input logic [7:0] dwe, input logic [63:0] da, input logic [63:0] dwd,
                     input logic eig, input logic edg);
    vec_t v;
    v.ir = ir; v.ia = ia; v.dr = dr; v.dwe = dwe; v.da = da; v.dwd = dwd;
    v.eig = eig; v.edg = edg;
    vecs.push_back(v);
  endtask

  task automatic check_rvalid(input string tag);
    sb_t e;
    e = '{iv: 1'b0, dv: 1'b0, rd: 64'h0};
    if (sbq.size() > 0) e = sbq.pop_front();
    chk({tag, " inst_rvalid"}, 64'(inst_rvalid), 64'(e.iv));
    chk({tag, " data_rvalid"}, 64'(data_rvalid), 64'(e.dv));
    chk({tag, " inst_rdata"}, inst_rdata, e.iv ? e.rd : 64'h0);
    chk({tag, " data_rdata"}, data_rdata, e.dv ? e.rd : 64'h0);
  endtask

  task automatic apply(input vec_t v, input int idx);
    string tag;
    sb_t   s;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    inst_req = v.ir; inst_addr = v.ia;
    data_req = v.dr; data_we = v.dwe; data_addr = v.da; data_wdata = v.dwd;
    #2;
    chk({tag, " inst_gnt"}, 64'(inst_gnt), 64'(v.eig));
    chk({tag, " data_gnt"}, 64'(data_gnt), 64'(v.edg));
    chk({tag, " mem_en"}, 64'(mem_en), 64'(v.eig | v.edg));
    chk({tag, " mem_addr"}, mem_addr, v.eig ? v.ia : (v.edg ? v.da : 64'h0));
    chk({tag, " mem_we"}, 64'(mem_we), v.edg ? 64'(v.dwe) : 64'h0);
    chk({tag, " mem_wdata"}, mem_wdata, v.edg ? v.dwd : 64'h0);
    chk({tag, " stallreq"}, 64'(stallreq), 64'((v.ir & ~v.eig) | (v.dr & ~v.edg)));
    check_rvalid(tag);
    s.iv = v.eig;
    s.dv = v.edg & (v.dwe == 8'h00);
    s.rd = mem_f(v.eig ? v.ia : v.da);
    sbq.push_back(s);
  endtask

  task automatic drive_idle();
    inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_we = '0; data_addr = '0; data_wdata = '0;
  endtask

  initial begin
    drive_idle();
    rst_n = 1'b0;
    // Requests asserted during reset must not be granted or stall.
    inst_req = 1'b1; data_req = 1'b1;
    #12;
    chk("rst inst_gnt", 64'(inst_gnt), 64'h0);
    chk("rst data_gnt", 64'(data_gnt), 64'h0);
    chk("rst mem_en", 64'(mem_en), 64'h0);
    chk("rst stallreq", 64'(stallreq), 64'h0);
    chk("rst rvalid", 64'({inst_rvalid, data_rvalid}), 64'h0);
    @(negedge clk);
    drive_idle();
    rst_n = 1'b1;

    //   ir    ia               dr    we     da        wdata                  eig   edg
    add(1'b0, 64'h0,           1'b0, 8'h00, 64'h0,    64'h0,                 1'b0, 1'b0);
    add(1'b1, 64'h8000_0000,   1'b0, 8'h00, 64'h0,    64'h0,                 1'b1, 1'b0);
    add(1'b0, 64'h0,           1'b0, 8'h00, 64'h0,    64'h0,                 1'b0, 1'b0);
    add(1'b1, 64'h8000_0000,   1'b1, 8'h00, 64'h100,  64'h0,                 1'b0, 1'b1);
    add(1'b1, 64'h8000_0000,   1'b0, 8'h00, 64'h0,    64'h0,                 1'b1, 1'b0);
    add(1'b0, 64'h0,           1'b0, 8'h00, 64'h0,    64'h0,                 1'b0, 1'b0);
    add(1'b0, 64'h0,           1'b1, 8'h0F, 64'h200,  64'h1122_3344_5566_7788, 1'b0, 1'b1);
    add(1'b0, 64'h0,           1'b0, 8'h00, 64'h0,    64'h0,                 1'b0, 1'b0);
    // Starvation: D,D,D,D,I,D with both held.
    for (int i = 0; i < 4; i++)
      add(1'b1, 64'h4000,      1'b1, 8'h00, 64'h300 + 64'(i * 8), 64'h0,   1'b0, 1'b1);
    add(1'b1, 64'h4000,        1'b1, 8'h00, 64'h320,  64'h0,                 1'b1, 1'b0);
    add(1'b0, 64'h0,           1'b1, 8'h00, 64'h320,  64'h0,                 1'b0, 1'b1);
    // Dropping inst_req clears the starvation count.
    add(1'b1, 64'h5000,        1'b1, 8'h00, 64'h400,  64'h0,                 1'b0, 1'b1);
    add(1'b1, 64'h5000,        1'b1, 8'h00, 64'h408,  64'h0,                 1'b0, 1'b1);
    add(1'b0, 64'h0,           1'b1, 8'h00, 64'h410,  64'h0,                 1'b0, 1'b1);
    for (int i = 0; i < 4; i++)
      add(1'b1, 64'h6000,      1'b1, 8'hFF, 64'h500 + 64'(i * 8), 64'hCAFE, 1'b0, 1'b1);
    add(1'b1, 64'h6000,        1'b1, 8'hFF, 64'h520,  64'hCAFE,              1'b1, 1'b0);
    add(1'b0, 64'h0,           1'b0, 8'h00, 64'h0,    64'h0,                 1'b0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // In-flight read killed by reset.
    sbq.delete();
    @(negedge clk);
    drive_idle();
    inst_req = 1'b1; inst_addr = 64'h1000;
    #2;
    chk("rr inst_gnt", 64'(inst_gnt), 64'h1);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    chk("rr inst_rvalid", 64'(inst_rvalid), 64'h0);
    chk("rr inst_rdata", inst_rdata, 64'h0);
    chk("rr inst_gnt", 64'(inst_gnt), 64'h0);
    chk("rr mem_en", 64'(mem_en), 64'h0);
    chk("rr mem_addr", mem_addr, 64'h0);
    chk("rr stallreq", 64'(stallreq), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    inst_addr = 64'h3000;
    #2;
    chk("post inst_gnt", 64'(inst_gnt), 64'h1);
    chk("post mem_addr", mem_addr, 64'h3000);
    chk("post rvalid", 64'(inst_rvalid), 64'h0);
    @(negedge clk);
    drive_idle();
    #2;
    chk("post inst_rvalid", 64'(inst_rvalid), 64'h1);
    chk("post inst_rdata", inst_rdata, mem_f(64'h3000));
    chk("post data_rvalid", 64'(data_rvalid), 64'h0);

`ifdef ARB_PERF_CNT_EN
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("perf reset", perf_conflict | perf_inst_gnt | perf_data_gnt, 64'h0);
    inst_req = 1'b1; inst_addr = 64'h7000;
    data_req = 1'b1; data_addr = 64'h700;
    repeat (10) @(negedge clk);
    drive_idle();
    #2;
    chk("perf_conflict", perf_conflict, 64'd10);
    chk("perf_data_gnt", perf_data_gnt, 64'd8);
    chk("perf_inst_gnt", perf_inst_gnt, 64'd2);
`endif

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
